// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader
//   Boot loader in front of the core's instruction memory. It takes a byte
//   stream over valid/ready: a 4-byte little-endian word count, then that many
//   little-endian instruction words. Each word is written to imem with a
//   one-cycle strobe. The core is held in reset until the image is complete.
//   After that the loader releases core_reset and stays inert until `reset`.
//
//   Optional feature, macro LOADER_CHECKSUM_EN: after the image, a 4-byte
//   checksum is expected. It must equal the 32-bit modular sum of all words,
//   otherwise the loader ends in the error state.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   in_valid/in_ready    byte-stream handshake (in_ready is registered)
//   in_data[7:0]         stream byte
//   imem_wr              one-cycle instruction-memory write strobe
//   imem_addr/imem_wdata write byte address / data (hold between strobes)
//   core_reset           high while loading or in error
//   done                 image loaded, core released
//   error                bad length or checksum, load aborted
module riscv_imem_loader #(
    parameter int unsigned          BUS_WIDTH = 32,
    parameter int unsigned          MAX_WORDS = 1024,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 imem_wr,
    output logic [BUS_WIDTH-1:0] imem_addr,
    output logic [BUS_WIDTH-1:0] imem_wdata,
    output logic                 core_reset,
    output logic                 done,
    output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_LEN, ST_LOAD, ST_CSUM, ST_RUN, ST_ERR} state_t;
    localparam state_t ST_POST = ST_CSUM;   // where the image phase ends
`else
    typedef enum logic [2:0] {ST_LEN, ST_LOAD, ST_RUN, ST_ERR} state_t;
    localparam state_t ST_POST = ST_RUN;
`endif

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;       // byte index within the word
    logic [23:0]            buf_q, buf_d;       // first three bytes of the word
    logic [31:0]            len_q, len_d;
    logic [31:0]            cnt_q, cnt_d;       // words written so far
    logic                   in_ready_q, in_ready_d;
    logic                   wr_q, wr_d;
    logic [BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]            sum_q, sum_d;
`endif

    logic        xfer;
    logic        last_byte;
    logic [31:0] word;

    assign xfer      = in_valid & in_ready_q;
    assign last_byte = xfer && (idx_q == 2'd3);
    // buf_q shifts in from the top, so after three bytes it holds {b2,b1,b0}
    assign word      = {in_data, buf_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (xfer) begin
            idx_d = idx_q + 2'd1;
            buf_d = {in_data, buf_q[23:8]};
        end

        case (state_q)
            ST_LEN: begin
                if (last_byte) begin
                    len_d = word;
                    cnt_d = '0;
                    if (word == 32'd0)          state_d = ST_POST;
                    else if (word > MAX_WORDS)  state_d = ST_ERR;
                    else                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The write pulse of the last word is issued while still in
                // LOAD; leaving one cycle later puts done right after it.
                if (cnt_q == len_q) begin
                    state_d = ST_POST;
                end else if (last_byte) begin
                    wr_d    = 1'b1;
                    addr_d  = BASE_ADDR + BUS_WIDTH'({cnt_q[29:0], 2'b00});
                    wdata_d = BUS_WIDTH'(word);
                    cnt_d   = cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + word;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (last_byte) state_d = (word == sum_q) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN:  ;
            ST_ERR:  ;
            default: state_d = ST_ERR;
        endcase

        // No bytes are taken during the final write-pulse cycle.
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_LOAD)
`ifdef LOADER_CHECKSUM_EN
                     || (state_d == ST_CSUM)
`endif
                     ;
        if (state_d == ST_LOAD && cnt_d == len_d) in_ready_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LEN;
            idx_q      <= '0;
            buf_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_wr    = wr_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == ST_RUN);
    assign core_reset = (state_q != ST_RUN);
    assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_riscv_imem_loader.sv
module tb_riscv_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_wr, core_reset, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    riscv_imem_loader #(.BUS_WIDTH(32), .MAX_WORDS(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .imem_wr(imem_wr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest pending expected write.
    always @(negedge clk) begin
        if (imem_wr) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== {e.a, e.d}) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a byte, wait (bounded) for in_ready, return 1ns after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0], gap);
            t = t >> 8;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Two-word image 0x00100513, 0x0000006F and its completion checks.
    task automatic two_word_image(input int gap, input string tag);
        exp_q.push_back('{a: 32'h0, d: 32'h00100513});
        exp_q.push_back('{a: 32'h4, d: 32'h0000006F});
        send_word(32'd2, gap);
        send_word(32'h00100513, gap);
        send_word(32'h0000006F, gap);
`ifndef LOADER_CHECKSUM_EN
        @(negedge clk);  // last write-pulse cycle: core still held
        n_cmp++;
        if (core_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s pulse_cycle: got core_reset=%b done=%b in_ready=%b, expected 1 0 0",
                     tag, core_reset, done, in_ready);
        end
`else
        send_word(32'h00100582, gap);
`endif
        @(negedge clk);
        n_cmp++;
        if (core_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: got core_reset=%b done=%b error=%b in_ready=%b, expected 0 1 0 0",
                     tag, core_reset, done, error, in_ready);
        end
        in_valid = 1'b1; in_data = 8'h55;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || core_reset !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s hold_run: got done=%b core_reset=%b in_ready=%b, expected 1 0 0",
                     tag, done, core_reset, in_ready);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s writes_seen: got %0d pending writes, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, imem_wr, core_reset, done, error} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready/wr/core_reset/done/error=%b, expected 00100",
                     {in_ready, imem_wr, core_reset, done, error});
        end
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%h data=%h, expected 0 0", imem_addr, imem_wdata);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got in_ready=%b core_reset=%b, expected 1 1", in_ready, core_reset);
        end
    endtask

    task automatic test_load_two();
        do_reset();
        two_word_image(0, "load_two");
    endtask

    task automatic test_gaps();
        do_reset();
        two_word_image(3, "gaps");
    endtask

    task automatic test_zero_len();
        do_reset();
        send_word(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 0);
`endif
        @(negedge clk);
        n_cmp++;
        if (core_reset !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_len: got core_reset=%b done=%b in_ready=%b error=%b, expected 0 1 0 0",
                     core_reset, done, in_ready, error);
        end
    endtask

    task automatic test_max_len();
        do_reset();
        send_word(32'd4, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b0 || in_ready !== 1'b1 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL max_len: got error=%b in_ready=%b core_reset=%b, expected 0 1 1",
                     error, in_ready, core_reset);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_word(32'd5, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL oversize: got error=%b core_reset=%b in_ready=%b done=%b, expected 1 1 0 0",
                     error, core_reset, in_ready, done);
        end
        in_valid = 1'b1; in_data = 8'h13;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (error !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL oversize_hold: got error=%b core_reset=%b in_ready=%b, expected 1 1 0",
                     error, core_reset, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        // reset with a byte on offer: it must not be taken
        in_valid = 1'b1; in_data = 8'hCC; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (core_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got core_reset=%b in_ready=%b, expected 1 0", core_reset, in_ready);
        end
        reset = 1'b0; in_valid = 1'b0;
        two_word_image(0, "reset_mid");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        exp_q.push_back('{a: 32'h0, d: 32'h00000013});
        send_word(32'd1, 0);
        send_word(32'h00000013, 0);
        send_word(32'h00000013, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_good: got done=%b core_reset=%b error=%b, expected 1 0 0", done, core_reset, error);
        end
        do_reset();
        exp_q.push_back('{a: 32'h0, d: 32'h00000013});
        send_word(32'd1, 0);
        send_word(32'h00000013, 0);
        send_word(32'h00000014, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_bad: got error=%b core_reset=%b done=%b, expected 1 1 0", error, core_reset, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_two();
        test_zero_len();
        test_max_len();
        test_oversize();
        test_gaps();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_imem_loader.md
Name: riscv_imem_loader

Overview:
Boot loader upstream of the RISC-V core's instruction memory. Receives a byte stream (length header, instruction words, optional checksum) over a valid/ready handshake. Writes each assembled 32-bit word into instruction memory and holds the core in reset until the image is fully written. It then releases `core_reset` and goes inert until the next `reset`.

Parameters:
- BUS_WIDTH, 32, width of imem address/data buses.
- MAX_WORDS, 1024, largest accepted image size in words.
- BASE_ADDR, 0, byte address of first instruction word; word k written at BASE_ADDR + 4*k.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  loader can accept a byte.
- in_data  input  8  stream byte.
- imem_wr  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  BUS_WIDTH  write byte address.
- imem_wdata  output  BUS_WIDTH  write data.
- core_reset  output  1  reset to core; high while loading or in error.
- done  output  1  image loaded, core released.
- error  output  1  load aborted (bad length or checksum).

Behaviour:
- One clock; reset is synchronous and active-high; clk/reset named as in the core.
- Reset values:
  - state=LEN, in_ready=0, imem_wr=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, done=0, error=0.
  - Byte counter, word counter, length and sum registers all 0.
- `in_ready` is registered. It is 1 in LEN, LOAD and CSUM from the first cycle after reset deasserts. It is 0 in RUN and ERR.
- Byte transfer occurs on a posedge where in_valid && in_ready. in_valid low cycles are gaps; state holds.
- Bytes are assembled little-endian: first byte -> bits [7:0], fourth byte -> [31:24]. The 2-bit byte index wraps 3->0.
- States:
  - LEN: accumulate 4 bytes into `len`. On the 4th byte:
    - len==0 -> RUN (or CSUM with feature).
    - len>MAX_WORDS -> ERR.
    - otherwise -> LOAD.
  - LOAD: on each 4th byte, in the next cycle:
    - imem_wr=1 for exactly one cycle.
    - imem_addr=BASE_ADDR+4*word_cnt.
    - imem_wdata=assembled word.
    - word_cnt increments.
    - When word_cnt reaches len -> RUN (or CSUM).
  - RUN:
    - Entered the cycle after the last imem_wr pulse; in that cycle core_reset=0 and done=1.
    - Both hold until reset.
    - imem_wr is never asserted again.
  - ERR: error=1, core_reset=1, in_ready=0; holds until reset.
- imem_addr and imem_wdata hold their last values between strobes.
- Arithmetic is modulo 2^BUS_WIDTH. word_cnt is compared against len with full-width equality.
- Reset mid-operation:
  - Any partial word is discarded; all counters are cleared; state returns to LEN.
  - core_reset=1 on the first cycle after the reset edge.
  - Already-written memory is not cleared.
- `reset` asserted while in_valid is high: the byte is not accepted.

Optional Feature:
- Macro `LOADER_CHECKSUM_EN`.
- Defined:
  - After the last word (or len==0), state CSUM accepts 4 more bytes, little-endian.
  - The value is compared with the 32-bit modular sum of all loaded words.
  - Equal -> RUN the cycle after the 4th checksum byte.
  - Unequal -> ERR, core stays in reset.
  - Checksum bytes never produce imem_wr.
- Undefined: CSUM state and the sum register are absent; LOAD/LEN go directly to RUN.

Test Plan:
- Load 2 words. Stream 02 00 00 00 | 13 05 10 00 | 6F 00 00 00 -> imem_wr pulses with (0x0,0x00100513), then (0x4,0x0000006F). Next cycle core_reset=0 and done=1; in_ready=0 afterwards.
- Zero length. Stream 00 00 00 00 (no checksum build) -> no imem_wr; core_reset falls the cycle after the 4th byte accepted.
- Oversize image, MAX_WORDS=4. Stream 05 00 00 00 -> error=1 and core_reset=1 persist; in_ready=0; no imem_wr.
- Backpressure gaps. Same stream as the 2-word case, with in_valid low for 3 cycles between every byte -> identical write sequence, delayed only by the gaps; no duplicate strobes.
- Reset mid-load. After header 02 00 00 00 plus 2 data bytes, pulse reset one cycle, then send the full 2-word stream -> first write is at address 0x0 with the new data; the stale partial bytes never appear.
- Checksum, with LOADER_CHECKSUM_EN. 1 word 0x00000013 followed by checksum 13 00 00 00 -> done=1. With checksum 14 00 00 00 -> error=1, core_reset stays 1.
